// File: rtl/register_bank.sv
// Multi-port register bank: one write port, two registered read ports with
// write bypass, and a per-register pending-write flag set by mark, cleared by write.
module register_bank #(
  parameter int N    = 16,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  // write port
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  // read port A
  input  logic          ren_a,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  // read port B
  input  logic          ren_b,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  // pending-write tracking
  input  logic          mark,
  input  logic [AW-1:0] mark_addr,
  input  logic          clr,
  output logic          busy_a,
  output logic          busy_b,
  output logic          any_busy
);

  logic [N-1:0]    mem_q [REGS];
  logic [N-1:0]    mem_d [REGS];
  logic [REGS-1:0] pend_q, pend_d;

  logic [N-1:0]    rdata_a_q, rdata_a_d;
  logic [N-1:0]    rdata_b_q, rdata_b_d;
  logic            busy_a_q,  busy_a_d;
  logic            busy_b_q,  busy_b_d;

  // Post-edge view of the bank: clr beats everything, and mark beats wen on
  // the flags. Reads sample this view, which gives bypass for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clr) begin
      for (int i = 0; i < REGS; i++) mem_d[i] = '0;
      pend_d = '0;
    end else begin
      if (wen) begin
        mem_d[waddr]  = wdata;
        pend_d[waddr] = 1'b0;
      end
      if (mark) pend_d[mark_addr] = 1'b1;
    end
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    busy_a_d  = busy_a_q;
    rdata_b_d = rdata_b_q;
    busy_b_d  = busy_b_q;
    if (ren_a) begin
      rdata_a_d = mem_d[raddr_a];
      busy_a_d  = pend_d[raddr_a];
    end
    if (ren_b) begin
      rdata_b_d = mem_d[raddr_b];
      busy_b_d  = pend_d[raddr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset here because the bank must read 0
      // after reset; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < REGS; i++) mem_q[i] <= '0;
      pend_q    <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      busy_a_q  <= 1'b0;
      busy_b_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q     <= mem_d;
      pend_q    <= pend_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      busy_a_q  <= busy_a_d;
      busy_b_q  <= busy_b_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign busy_a   = busy_a_q;
  assign busy_b   = busy_b_q;
  assign any_busy = |pend_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: read expectations are queued when the read
// is issued and compared one edge later; combinational flags are checked in place.
module tb_register_bank;

  localparam int N    = 16;
  localparam int REGS = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          ren_a, ren_b;
  logic [AW-1:0] raddr_a, raddr_b;
  logic [N-1:0]  rdata_a, rdata_b;
  logic          mark;
  logic [AW-1:0] mark_addr;
  logic          clr;
  logic          busy_a, busy_b, any_busy;

  register_bank #(.N(N), .REGS(REGS), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .ren_a    (ren_a),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .ren_b    (ren_b),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .mark     (mark),
    .mark_addr(mark_addr),
    .clr      (clr),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .any_busy (any_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    bit           port_b;
    logic [N-1:0] data;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input string tag, input bit port_b,
                             input logic [N-1:0] data, input logic busy);
    exp_t e;
    e.tag = tag; e.port_b = port_b; e.data = data; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic idle();
    wen = 1'b0; ren_a = 1'b0; ren_b = 1'b0; mark = 1'b0; clr = 1'b0;
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then every
  // expectation queued for this edge is retired.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port_b) begin
        check({e.tag, "_rdata_b"}, 32'(rdata_b), 32'(e.data));
        check({e.tag, "_busy_b"},  32'(busy_b),  32'(e.busy));
      end else begin
        check({e.tag, "_rdata_a"}, 32'(rdata_a), 32'(e.data));
        check({e.tag, "_busy_a"},  32'(busy_a),  32'(e.busy));
      end
    end
    idle();
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    ren_a = 1'b1; raddr_a = a;
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    ren_b = 1'b1; raddr_b = a;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [N-1:0] d);
    wen = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic mk(input logic [AW-1:0] a);
    mark = 1'b1; mark_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; mark_addr = '0;

    // Reset state
    #3;
    check("rst_rdata_a", 32'(rdata_a), 0);
    check("rst_rdata_b", 32'(rdata_b), 0);
    check("rst_busy_a",  32'(busy_a),  0);
    check("rst_busy_b",  32'(busy_b),  0);
    check("rst_any",     32'(any_busy), 0);
    #9 rst_n = 1'b1;

    // Plain write then registered read
    wr(3'd3, 16'h1234);
    tick();
    rd_a(3'd3); expect_read("r3_read", 1'b0, 16'h1234, 1'b0);
    tick();

    // Same-edge write and dual read: bypass on both ports
    wr(3'd5, 16'hBEEF); rd_a(3'd5); rd_b(3'd5);
    expect_read("bypass5", 1'b0, 16'hBEEF, 1'b0);
    expect_read("bypass5", 1'b1, 16'hBEEF, 1'b0);
    tick();

    // Mark, observe busy, write clears it
    mk(3'd2);
    tick();
    check("mark2_any", 32'(any_busy), 1);
    rd_b(3'd2); expect_read("r2_marked", 1'b1, 16'h0000, 1'b1);
    tick();
    wr(3'd2, 16'h0007);
    tick();
    check("wr2_any", 32'(any_busy), 0);
    rd_b(3'd2); expect_read("r2_written", 1'b1, 16'h0007, 1'b0);
    tick();

    // ren low: outputs hold even though r2 changes
    wr(3'd2, 16'h0008);
    tick();
    check("hold_rdata_b", 32'(rdata_b), 32'h0007);
    check("hold_busy_b",  32'(busy_b),  0);

    // Mark and write on the same address: mark wins
    mk(3'd4); wr(3'd4, 16'h00FF);
    tick();
    check("mark_wins_any", 32'(any_busy), 1);
    rd_a(3'd4); expect_read("r4_mark_wins", 1'b0, 16'h00FF, 1'b1);
    tick();

    // Busy bypass: same-edge write clears (A), same-edge mark sets (B)
    rd_a(3'd4); wr(3'd4, 16'h0A0A);
    rd_b(3'd6); mk(3'd6);
    expect_read("busy_byp_wr",   1'b0, 16'h0A0A, 1'b0);
    expect_read("busy_byp_mark", 1'b1, 16'h0000, 1'b1);
    tick();
    check("r6_any", 32'(any_busy), 1);

    // Fill r0..r7, then mark r7
    for (int i = 0; i < REGS; i++) begin
      wr(AW'(i), N'(16'h1111 * i));
      tick();
    end
    check("fill_any", 32'(any_busy), 0);
    mk(3'd7);
    rd_b(3'd3); expect_read("fill_r3", 1'b1, 16'h3333, 1'b0);
    tick();
    check("r7_any", 32'(any_busy), 1);

    // clr overrides write and mark; same-cycle reads return 0
    clr = 1'b1; wr(3'd1, 16'hAAAA); mk(3'd0);
    rd_a(3'd1); rd_b(3'd7);
    expect_read("clr_r1", 1'b0, 16'h0000, 1'b0);
    expect_read("clr_r7", 1'b1, 16'h0000, 1'b0);
    tick();
    check("clr_any", 32'(any_busy), 0);
    for (int i = 0; i < REGS; i++) begin
      rd_a(AW'(i)); rd_b(AW'(REGS - 1 - i));
      expect_read("post_clr", 1'b0, 16'h0000, 1'b0);
      expect_read("post_clr", 1'b1, 16'h0000, 1'b0);
      tick();
    end

    // Asynchronous reset mid-cycle discards the pending write and mark
    wr(3'd1, 16'h5555); mk(3'd2);
    tick();
    check("pre_rst_any", 32'(any_busy), 1);
    rd_a(3'd1); rd_b(3'd2);
    expect_read("pre_rst_r1", 1'b0, 16'h5555, 1'b0);
    expect_read("pre_rst_r2", 1'b1, 16'h0000, 1'b1);
    tick();
    wr(3'd6, 16'h9999); mk(3'd6); rd_a(3'd6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rdata_a", 32'(rdata_a), 0);
    check("async_busy_b",  32'(busy_b),  0);
    check("async_any",     32'(any_busy), 0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    check("rst_held_any", 32'(any_busy), 0);
    for (int i = 0; i < REGS; i++) begin
      rd_a(AW'(i)); rd_b(AW'(i));
      expect_read("post_rst", 1'b0, 16'h0000, 1'b0);
      expect_read("post_rst", 1'b1, 16'h0000, 1'b0);
      tick();
    end

    // First edge after reset behaves normally
    wr(3'd0, 16'hC0DE); rd_a(3'd0);
    expect_read("post_rst_wr", 1'b0, 16'hC0DE, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
